// File: rtl/gates_capture.sv
// Capture FIFO behind the combinational gate block: buffers {y, vy} samples and presents
// the head entry with its popcount. Optional per-entry parity under GATES_CAPTURE_PARITY_EN.
module gates_capture #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       y,
    input  logic [0:W-1]               vy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_y,
    output logic [0:W-1]               out_vy,
    output logic [$clog2(W+1)-1:0]     out_ones,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 drop_cnt
`ifdef GATES_CAPTURE_PARITY_EN
    ,
    output logic                       out_par
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(W + 1);

    // Number of set bits in a vy vector.
    function automatic logic [OW-1:0] popcount(input logic [0:W-1] v);
        logic [OW-1:0] acc;
        acc = '0;
        for (int i = 0; i < W; i++) begin
            acc = acc + OW'(v[i]);
        end
        return acc;
    endfunction

    // Even parity over the scalar and vector results of one sample.
    function automatic logic entry_parity(input logic y_v, input logic [0:W-1] v);
        return y_v ^ (^v);
    endfunction

    logic [W:0]    mem_r [DEPTH];
`ifdef GATES_CAPTURE_PARITY_EN
    logic          par_mem_r [DEPTH];
`endif
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [7:0]    drop_cnt_r;

    logic          in_ready_s;
    logic          out_valid_s;
    logic          push_s;
    logic          pop_s;
    logic [W:0]    head_s;

    assign in_ready_s  = (count_r != CW'(DEPTH));
    assign out_valid_s = (count_r != CW'(0));
    assign push_s      = in_valid && in_ready_s;
    assign pop_s       = out_valid_s && out_ready;
    assign head_s      = mem_r[rd_ptr_r];

    // Pointer, occupancy and drop-counter state; reset discards any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= AW'(0);
            rd_ptr_r   <= AW'(0);
            count_r    <= CW'(0);
            drop_cnt_r <= 8'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (in_valid && !in_ready_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    // Entry storage is intentionally not reset; it is only visible when count is non-zero.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= {y, vy};
`ifdef GATES_CAPTURE_PARITY_EN
            par_mem_r[wr_ptr_r] <= entry_parity(y, vy);
`endif
        end
    end

    // Head-entry presentation, forced to zero while empty.
    always_comb begin
        out_y    = 1'b0;
        out_vy   = '0;
        out_ones = '0;
`ifdef GATES_CAPTURE_PARITY_EN
        out_par  = 1'b0;
`endif
        if (out_valid_s) begin
            out_y    = head_s[W];
            out_vy   = head_s[W-1:0];
            out_ones = popcount(head_s[W-1:0]);
`ifdef GATES_CAPTURE_PARITY_EN
            out_par  = par_mem_r[rd_ptr_r];
`endif
        end else begin
            out_y    = 1'b0;
            out_vy   = '0;
            out_ones = '0;
`ifdef GATES_CAPTURE_PARITY_EN
            out_par  = 1'b0;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign count     = count_r;
    assign drop_cnt  = drop_cnt_r;

endmodule
